axi_lite_sram_param: RTL and testbench

Parametrised AXI4-Lite SRAM slave with a synthesizable internal word array, byte-strobe writes, independent AW/W acceptance, per-direction programmable response latency, and address decode with error response. It replaces the fixed-width, DPI-backed memory model at the CPU memory port and can also be instantiated as a small on-chip scratchpad behind the interconnect.

---
 rtl/axi_lite_sram_param.sv | 183 ++++++++++++++++++
 tb/tb_axi_lite_sram_param.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_sram_param.sv
// AXI4-Lite SRAM slave: byte-lane word array, independent AW/W capture,
// per-direction programmable response latency and SLVERR outside the window.
module axi_lite_sram_param #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    RD_LATENCY = 1,
  parameter int                    WR_LATENCY = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_BITS   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = $clog2(DEPTH);
  localparam int MAX_LAT    = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_WIDTH  = $clog2(MAX_LAT + 1);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(DEPTH * STRB_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_COLLECT, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  w_state_t              w_state_reg, w_state_next;
  r_state_t              r_state_reg, r_state_next;
  logic [CNT_WIDTH-1:0]  w_cnt_reg, w_cnt_next;
  logic [CNT_WIDTH-1:0]  r_cnt_reg, r_cnt_next;
  logic                  aw_held_reg, w_held_reg;
  logic [ADDR_WIDTH-1:0] awaddr_reg, araddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_WIDTH-1:0] wstrb_reg;
  logic                  wr_commit, rd_capture, rd_sample;
  logic [ADDR_WIDTH:0]   wr_off, rd_off;
  logic                  wr_ok, rd_ok;
  logic [IDX_WIDTH-1:0]  wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] mem_q;

  // One extra offset bit makes addresses below the base wrap above SPAN.
  assign wr_off = {1'b0, awaddr_reg} - {1'b0, BASE_ADDR};
  assign rd_off = {1'b0, araddr_reg} - {1'b0, BASE_ADDR};
  assign wr_ok  = wr_off < SPAN;
  assign rd_ok  = rd_off < SPAN;
  assign wr_idx = wr_off[OFF_BITS +: IDX_WIDTH];
  assign rd_idx = rd_off[OFF_BITS +: IDX_WIDTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      w_state_reg <= W_COLLECT;
      r_state_reg <= R_IDLE;
      w_cnt_reg   <= '0;
      r_cnt_reg   <= '0;
    end else begin
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
      w_cnt_reg   <= w_cnt_next;
      r_cnt_reg   <= r_cnt_next;
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    w_cnt_next   = w_cnt_reg;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    wr_commit    = 1'b0;
    case (w_state_reg)
      W_COLLECT: begin
        awready = !aw_held_reg;
        wready  = !w_held_reg;
        if (aw_held_reg && w_held_reg) begin
          wr_commit    = 1'b1;
          w_cnt_next   = CNT_WIDTH'(WR_LATENCY - 1);
          w_state_next = (WR_LATENCY == 1) ? W_RESP : W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt_reg <= CNT_WIDTH'(1)) w_state_next = W_RESP;
        else                            w_cnt_next   = w_cnt_reg - 1'b1;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_next = W_COLLECT;
      end
      default: w_state_next = W_COLLECT;
    endcase
  end

  always_comb begin
    r_state_next = r_state_reg;
    r_cnt_next   = r_cnt_reg;
    arready      = 1'b0;
    rvalid       = 1'b0;
    rd_capture   = 1'b0;
    rd_sample    = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          rd_capture   = 1'b1;
          r_cnt_next   = CNT_WIDTH'(RD_LATENCY - 1);
          r_state_next = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_reg == '0) begin
          rd_sample    = 1'b1;
          r_state_next = R_RESP;
        end else begin
          r_cnt_next = r_cnt_reg - 1'b1;
        end
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      araddr_reg  <= '0;
    end else begin
      if (bvalid && bready) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
      end else begin
        if (awvalid && awready) begin
          aw_held_reg <= 1'b1;
          awaddr_reg  <= awaddr;
        end
        if (wvalid && wready) begin
          w_held_reg <= 1'b1;
          wdata_reg  <= wdata;
          wstrb_reg  <= wstrb;
        end
      end
      if (rd_capture) araddr_reg <= araddr;
    end
  end

  // One RAM per byte lane; read and write in one block gives read-before-write.
  generate
    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q;
      always_ff @(posedge i_clk) begin
        if (wr_commit && wr_ok && wstrb_reg[gi]) lane_mem[wr_idx] <= wdata_reg[gi*8 +: 8];
        if (rd_sample) lane_q <= lane_mem[rd_idx];
      end
      assign mem_q[gi*8 +: 8] = lane_q;
    end
  endgenerate

  assign bresp = (bvalid && !wr_ok) ? RESP_SLVERR : RESP_OKAY;
  assign rresp = (rvalid && !rd_ok) ? RESP_SLVERR : RESP_OKAY;
  assign rdata = (rvalid && rd_ok) ? mem_q : '0;
endmodule

// File: tb/tb_axi_lite_sram_param.sv
// Scenario bench for axi_lite_sram_param: scoreboard queues of expected
// responses plus a byte-lane reference model of the array.
module tb_axi_lite_sram_param;
  localparam int          DEPTH = 256;
  localparam int          RDL   = 3;
  localparam int          WRL   = 4;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  axi_lite_sram_param #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .RD_LATENCY(RDL), .WR_LATENCY(WRL)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic [31:0] data; logic [1:0] resp; } rexp_t;
  logic [1:0]  b_q[$];
  rexp_t       r_q[$];
  logic [31:0] model [int];
  int n_checks = 0, n_fail = 0;

  function automatic bit in_rng(logic [31:0] a);
    return (a >= BASE) && (a < BASE + DEPTH * 4);
  endfunction

  function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    logic [31:0] w;
    int idx;
    if (!in_rng(a)) return;
    idx = int'((a - BASE) >> 2);
    w = model.exists(idx) ? model[idx] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    model[idx] = w;
  endfunction

  function automatic rexp_t model_read(logic [31:0] a);
    rexp_t e;
    if (!in_rng(a)) begin e.data = 32'h0; e.resp = 2'b10; end
    else begin e.data = model[int'((a - BASE) >> 2)]; e.resp = 2'b00; end
    return e;
  endfunction

  // Drive AW and W starting aw_d / w_d cycles from now; returns just after the later handshake edge.
  task automatic aw_w_hs(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int aw_d, input int w_d, output bit ok);
    bit aw_done, w_done, aw_hs, w_hs;
    aw_done = 0; w_done = 0; ok = 1;
    for (int t = 0; !(aw_done && w_done); t++) begin
      if (t > 50) begin ok = 0; break; end
      awaddr = a; wdata = d; wstrb = s;
      awvalid = !aw_done && (t >= aw_d);
      wvalid  = !w_done && (t >= w_d);
      #1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge i_clk); #1;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
    end
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp, output int lat);
    lat = -1; resp = 2'bxx;
    for (int k = 0; k <= 40; k++) begin
      if (bvalid === 1'b1) begin lat = k; resp = bresp; break; end
      @(posedge i_clk); #1;
    end
    if (lat >= 0) begin @(posedge i_clk); #1; end
  endtask

  task automatic ar_hs(input logic [31:0] a, output bit ok);
    bit hs;
    ok = 0;
    araddr = a; arvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      #1; hs = arready;
      @(posedge i_clk); #1;
      if (hs) begin ok = 1; break; end
    end
    arvalid = 1'b0;
  endtask

  task automatic wait_r(output logic [31:0] d, output logic [1:0] resp, output int lat);
    lat = -1; d = 'x; resp = 2'bxx;
    for (int k = 0; k <= 40; k++) begin
      if (rvalid === 1'b1) begin lat = k; d = rdata; resp = rresp; break; end
      @(posedge i_clk); #1;
    end
    if (lat >= 0 && rready) begin @(posedge i_clk); #1; end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_d, input int w_d, output logic [1:0] resp, output int lat);
    bit ok;
    b_q.push_back(in_rng(a) ? 2'b00 : 2'b10);
    model_write(a, d, s);
    aw_w_hs(a, d, s, aw_d, w_d, ok);
    resp = 2'bxx; lat = -1;
    if (ok) wait_b(resp, lat);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int lat);
    bit ok;
    r_q.push_back(model_read(a));
    ar_hs(a, ok);
    d = 'x; resp = 2'bxx; lat = -1;
    if (ok) wait_r(d, resp, lat);
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b111_00_0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 111000000",
                         {awready, wready, arready, bvalid, rvalid, bresp, rresp});
    end
    n_checks++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      n_fail++; $display("FAIL reset_idle: got %b expected 11100", {awready, wready, arready, bvalid, rvalid});
    end
    $display("reset: checked idle outputs");
  endtask

  task automatic test_basic();
    logic [1:0] resp, eb; logic [31:0] d; int lat; rexp_t er;
    do_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat);
    eb = b_q.pop_front();
    n_checks++; if (resp !== eb) begin n_fail++; $display("FAIL basic_bresp: got %b expected %b", resp, eb); end
    n_checks++; if (lat !== WRL) begin n_fail++; $display("FAIL basic_wlat: got %0d expected %0d", lat, WRL); end
    n_checks++;
    if ({awready, wready, bvalid} !== 3'b110) begin
      n_fail++; $display("FAIL basic_wready_back: got %b expected 110", {awready, wready, bvalid});
    end
    do_read(BASE + 32'h10, d, resp, lat);
    er = r_q.pop_front();
    n_checks++; if (d !== er.data) begin n_fail++; $display("FAIL basic_rdata: got %h expected %h", d, er.data); end
    n_checks++; if (resp !== er.resp) begin n_fail++; $display("FAIL basic_rresp: got %b expected %b", resp, er.resp); end
    n_checks++; if (lat !== RDL) begin n_fail++; $display("FAIL basic_rlat: got %0d expected %0d", lat, RDL); end
    n_checks++;
    if ({arready, rvalid} !== 2'b10) begin
      n_fail++; $display("FAIL basic_arready_back: got %b expected 10", {arready, rvalid});
    end
    $display("basic: write+read 0x%h data %h lat w%0d r%0d", BASE + 32'h10, d, WRL, lat);
  endtask

  task automatic test_partial_strobe();
    logic [1:0] resp, eb; logic [31:0] d; int lat; rexp_t er;
    do_write(BASE + 32'h20, 32'h11223344, 4'hF, 0, 0, resp, lat);
    eb = b_q.pop_front();
    n_checks++; if (resp !== eb) begin n_fail++; $display("FAIL strobe_bresp1: got %b expected %b", resp, eb); end
    do_write(BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, resp, lat);
    eb = b_q.pop_front();
    n_checks++; if (resp !== eb) begin n_fail++; $display("FAIL strobe_bresp2: got %b expected %b", resp, eb); end
    do_read(BASE + 32'h20, d, resp, lat);
    er = r_q.pop_front();
    n_checks++; if (d !== er.data) begin n_fail++; $display("FAIL strobe_rdata: got %h expected %h", d, er.data); end
    $display("partial_strobe: read %h", d);
  endtask

  task automatic test_aw_w_order(input bit aw_first);
    logic [1:0] resp, eb; logic [31:0] d, a, v; int lat; rexp_t er;
    a = aw_first ? BASE + 32'h40 : BASE + 32'h44;
    v = aw_first ? 32'hCAFEF00D : 32'h600DD00D;
    b_q.push_back(2'b00);
    model_write(a, v, 4'hF);
    awaddr = a; wdata = v; wstrb = 4'hF;
    if (aw_first) awvalid = 1'b1; else wvalid = 1'b1;
    @(posedge i_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({awready, wready} !== (aw_first ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL order_ready(aw_first=%0d,cyc %0d): got %b", aw_first, i, {awready, wready});
      end
      @(posedge i_clk); #1;
    end
    if (aw_first) wvalid = 1'b1; else awvalid = 1'b1;
    @(posedge i_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b(resp, lat);
    eb = b_q.pop_front();
    n_checks++; if (resp !== eb) begin n_fail++; $display("FAIL order_bresp: got %b expected %b", resp, eb); end
    n_checks++; if (lat !== WRL) begin n_fail++; $display("FAIL order_wlat: got %0d expected %0d", lat, WRL); end
    @(posedge i_clk); #1;
    n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL order_single_b: bvalid %b expected 0", bvalid); end
    do_read(a, d, resp, lat);
    er = r_q.pop_front();
    n_checks++; if (d !== er.data) begin n_fail++; $display("FAIL order_rdata: got %h expected %h", d, er.data); end
    $display("aw_w_order: aw_first=%0d read %h", aw_first, d);
  endtask

  task automatic test_out_of_range();
    logic [31:0] wa[3], ra[4], wv[3];
    logic [1:0] resp, eb; logic [31:0] d; int lat; rexp_t er;
    wa[0] = BASE; wa[1] = BASE + 32'h3FC; wa[2] = BASE + DEPTH * 4;
    wv[0] = 32'h5A5A1234; wv[1] = 32'h0BADCAFE; wv[2] = 32'hFFFFFFFF;
    ra[0] = BASE + DEPTH * 4; ra[1] = BASE - 32'h4; ra[2] = BASE; ra[3] = BASE + 32'h3FC;
    for (int i = 0; i < 3; i++) begin
      do_write(wa[i], wv[i], 4'hF, 0, 0, resp, lat);
      eb = b_q.pop_front();
      n_checks++;
      if (resp !== eb || lat !== WRL) begin
        n_fail++; $display("FAIL oor_write %h: bresp %b lat %0d expected %b lat %0d", wa[i], resp, lat, eb, WRL);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(ra[i], d, resp, lat);
      er = r_q.pop_front();
      n_checks++;
      if (d !== er.data || resp !== er.resp) begin
        n_fail++; $display("FAIL oor_read %h: got %h/%b expected %h/%b", ra[i], d, resp, er.data, er.resp);
      end
      $display("out_of_range: read %h -> %h resp %b", ra[i], d, resp);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; logic [31:0] d; int lat; bit ok; rexp_t er;
    rready = 1'b0;
    r_q.push_back(model_read(BASE + 32'h10));
    ar_hs(BASE + 32'h10, ok);
    wait_r(d, resp, lat);
    er = r_q.pop_front();
    n_checks++; if (lat !== RDL) begin n_fail++; $display("FAIL bp_rlat: got %0d expected %0d", lat, RDL); end
    n_checks++; if (d !== er.data) begin n_fail++; $display("FAIL bp_rdata: got %h expected %h", d, er.data); end
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk); #1;
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== er.data || arready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cyc %0d: rvalid %b rdata %h arready %b expected 1 %h 0",
                           i, rvalid, rdata, arready, er.data);
      end
    end
    rready = 1'b1;
    @(posedge i_clk); #1;
    n_checks++;
    if ({rvalid, arready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release: rvalid/arready %b expected 01", {rvalid, arready});
    end
    $display("backpressure: held %h for 5 cycles", er.data);
  endtask

  task automatic test_reset_mid_write();
    logic [1:0] resp, eb; logic [31:0] d; int lat; bit ok, saw_b; rexp_t er;
    do_write(BASE + 32'h80, 32'h01020304, 4'hF, 0, 0, resp, lat);
    eb = b_q.pop_front();
    n_checks++; if (resp !== eb) begin n_fail++; $display("FAIL rst_pre_bresp: got %b expected %b", resp, eb); end
    for (int phase = 0; phase < 2; phase++) begin
      // phase 0: reset before the commit edge; phase 1: reset inside W_WAIT
      aw_w_hs(phase == 0 ? BASE + 32'h80 : BASE + 32'h84, 32'hFFFF0000, 4'hF, 0, 0, ok);
      if (phase == 1) begin @(posedge i_clk); #1; @(posedge i_clk); #1; end
      i_rst = 1'b1;
      #1;
      n_checks++;
      if ({awready, wready, arready, bvalid, bresp} !== 6'b111000) begin
        n_fail++; $display("FAIL rst_mid_outputs phase %0d: got %b expected 111000", phase,
                           {awready, wready, arready, bvalid, bresp});
      end
      #2 i_rst = 1'b0;
      saw_b = 0;
      for (int i = 0; i < WRL + 4; i++) begin
        @(posedge i_clk); #1;
        if (bvalid !== 1'b0) saw_b = 1;
      end
      n_checks++;
      if (saw_b || {awready, wready} !== 2'b11) begin
        n_fail++; $display("FAIL rst_mid_quiet phase %0d: saw_bvalid %0d ready %b expected 0 11", phase,
                           saw_b, {awready, wready});
      end
    end
    do_read(BASE + 32'h80, d, resp, lat);
    er = r_q.pop_front();
    n_checks++; if (d !== er.data) begin n_fail++; $display("FAIL rst_mid_old: got %h expected %h", d, er.data); end
    $display("reset_mid_write: word retains %h", d);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs[8];
    logic [1:0] resp, eb; logic [31:0] d; int lat; rexp_t er;
    for (int i = 0; i < 8; i++) begin
      addrs[i] = BASE + 32'h100 + 32'($urandom_range(0, 15)) * 4;
      do_write(addrs[i], $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), resp, lat);
      eb = b_q.pop_front();
      n_checks++;
      if (resp !== eb || lat !== WRL) begin
        n_fail++; $display("FAIL b2b_write %h: bresp %b lat %0d expected %b lat %0d", addrs[i], resp, lat, eb, WRL);
      end
    end
    for (int i = 0; i < 8; i++) begin
      do_read(addrs[i], d, resp, lat);
      er = r_q.pop_front();
      n_checks++;
      if (d !== er.data || resp !== er.resp || lat !== RDL) begin
        n_fail++; $display("FAIL b2b_read %h: got %h/%b lat %0d expected %h/%b lat %0d",
                           addrs[i], d, resp, lat, er.data, er.resp, RDL);
      end
      $display("back_to_back: read %h -> %h", addrs[i], d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_strobe();
    test_aw_w_order(1'b1);
    test_aw_w_order(1'b0);
    test_out_of_range();
    test_backpressure();
    test_reset_mid_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
